mgmt_arbiter: RTL and testbench

Two-master arbiter for the 32-bit management bus (req/ack/rxe protocol). It shares one management slave port between the core system-bus unit (master 0) and a debug/DMA requester (master 1). It latches the winning request, sequences the address and read-data phases, and forwards completions only to the granted master. A watchdog terminates transactions the slave never completes.

---
 rtl/mgmt_arbiter.sv | 110 +++++++++++
 tb/tb_mgmt_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mgmt_arbiter.sv
// mgmt_arbiter: two-master round-robin arbiter for the req/ack/rxe management bus with a phase watchdog
module mgmt_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst_n,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_adr,
  input  logic        i_m0_rwn,
  input  logic [1:0]  i_m0_wen,
  input  logic [31:0] i_m0_txd,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_adr,
  input  logic        i_m1_rwn,
  input  logic [1:0]  i_m1_wen,
  input  logic [31:0] i_m1_txd,
  output logic        o_m0_ack,
  output logic        o_m0_rxe,
  output logic [31:0] o_m0_rxd,
  output logic        o_m0_err,
  output logic        o_m1_ack,
  output logic        o_m1_rxe,
  output logic [31:0] o_m1_rxd,
  output logic        o_m1_err,
  output logic        o_s_req,
  output logic [31:0] o_s_adr,
  output logic        o_s_rwn,
  output logic [1:0]  o_s_wen,
  output logic [31:0] o_s_txd,
  input  logic        i_s_ack,
  input  logic        i_s_rxe,
  input  logic [31:0] i_s_rxd,
  output logic        o_busy,
  output logic        o_grant
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t      r_state, w_next;
  logic        r_grant, r_last, r_rwn;
  logic [1:0]  r_wen;
  logic [31:0] r_adr, r_txd, w_rxd;
  logic [15:0] r_cnt;
  logic        w_start, w_pick, w_to, w_ack, w_rxe, w_err;
  assign w_start = i_m0_req | i_m1_req;
  // a contest goes to the master that did not win last time; a lone requester always wins
  assign w_pick  = (i_m0_req & i_m1_req) ? ~r_last : i_m1_req;
  assign w_to    = r_cnt == 16'(TIMEOUT - 1);
  // next state and completion signals; a timeout completes the phase with zero data and an error pulse
  always_comb begin
    w_next = r_state;
    w_ack  = 1'b0;
    w_rxe  = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      IDLE: w_next = w_start ? ADDR : IDLE;
      ADDR: begin
        w_err  = w_to & ~i_s_ack;
        w_ack  = i_s_ack | w_to;
        w_rxe  = r_rwn & (i_s_rxe | w_err);
        w_next = i_s_ack ? ((r_rwn & ~i_s_rxe) ? DATA : IDLE) : (w_to ? IDLE : ADDR);
      end
      DATA: begin
        w_err  = w_to & ~i_s_rxe;
        w_rxe  = i_s_rxe | w_to;
        w_next = w_rxe ? IDLE : DATA;
      end
      default: w_next = IDLE;
    endcase
  end
  // read data reaches the master only during a live phase and is forced to zero on a timeout
  assign w_rxd = (r_state != IDLE && !w_err) ? i_s_rxd : 32'd0;
  // state, watchdog counter and latched command of the winning master
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_adr   <= '0;
      r_rwn   <= 1'b0;
      r_wen   <= '0;
      r_txd   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == IDLE || w_next != r_state) ? '0 : r_cnt + 16'd1;
      if (r_state == IDLE && w_start) begin
        r_grant <= w_pick;
        r_last  <= w_pick;
        r_adr   <= w_pick ? i_m1_adr : i_m0_adr;
        r_rwn   <= w_pick ? i_m1_rwn : i_m0_rwn;
        r_wen   <= w_pick ? i_m1_wen : i_m0_wen;
        r_txd   <= w_pick ? i_m1_txd : i_m0_txd;
      end
    end
  end
  assign o_s_req  = r_state == ADDR;
  assign o_busy   = r_state != IDLE;
  assign o_grant  = r_grant;
  assign o_s_adr  = r_adr;
  assign o_s_rwn  = r_rwn;
  assign o_s_wen  = r_wen;
  assign o_s_txd  = r_txd;
  assign o_m0_ack = w_ack & ~r_grant;
  assign o_m1_ack = w_ack & r_grant;
  assign o_m0_rxe = w_rxe & ~r_grant;
  assign o_m1_rxe = w_rxe & r_grant;
  assign o_m0_err = w_err & ~r_grant;
  assign o_m1_err = w_err & r_grant;
  assign o_m0_rxd = r_grant ? 32'd0 : w_rxd;
  assign o_m1_rxd = r_grant ? w_rxd : 32'd0;
endmodule

// File: tb/tb_mgmt_arbiter.sv
// tb_mgmt_arbiter: directed and randomized transactions checked against a phase-level arbiter model
module tb_mgmt_arbiter;
  localparam int TO = 8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [31:0] adr [2];
  logic [31:0] txd [2];
  logic        rwn [2];
  logic [1:0]  wen [2];
  logic        s_ack = 1'b0, s_rxe = 1'b0;
  logic [31:0] rdat = '0;
  logic        m0_ack, m0_rxe, m0_err, m1_ack, m1_rxe, m1_err;
  logic [31:0] m0_rxd, m1_rxd, s_adr, s_txd;
  logic        s_req, s_rwn, busy, grant;
  logic [1:0]  s_wen;
  int          checks = 0, failures = 0;
  bit          last = 1'b1;
  always #5 clk = ~clk;
  mgmt_arbiter #(.TIMEOUT(TO)) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n),
    .i_m0_req(req[0]), .i_m0_adr(adr[0]), .i_m0_rwn(rwn[0]), .i_m0_wen(wen[0]), .i_m0_txd(txd[0]),
    .i_m1_req(req[1]), .i_m1_adr(adr[1]), .i_m1_rwn(rwn[1]), .i_m1_wen(wen[1]), .i_m1_txd(txd[1]),
    .o_m0_ack(m0_ack), .o_m0_rxe(m0_rxe), .o_m0_rxd(m0_rxd), .o_m0_err(m0_err),
    .o_m1_ack(m1_ack), .o_m1_rxe(m1_rxe), .o_m1_rxd(m1_rxd), .o_m1_err(m1_err),
    .o_s_req(s_req), .o_s_adr(s_adr), .o_s_rwn(s_rwn), .o_s_wen(s_wen), .o_s_txd(s_txd),
    .i_s_ack(s_ack), .i_s_rxe(s_rxe), .i_s_rxd(rdat),
    .o_busy(busy), .o_grant(grant)
  );
  wire [1:0]  ack = {m1_ack, m0_ack};
  wire [1:0]  rxe = {m1_rxe, m0_rxe};
  wire [1:0]  err = {m1_err, m0_err};
  wire [31:0] rxd [2] = '{m0_rxd, m1_rxd};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_rxe"}, 32'(rxe), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // One transaction: masters in mask request together; slave acks ack_dly cycles into the
  // address phase and returns read data rxe_dly cycles after the ack (0 = same cycle).
  task automatic txn(input logic [1:0] mask, input int ack_dly, input int rxe_dly, input bit late);
    bit w, rd, to, done, data;
    int c;
    @(negedge clk);
    s_ack = 1'b0; s_rxe = 1'b0;
    req = mask;
    w = (req == 2'b11) ? !last : req[1];
    last = w;
    rd = rwn[w];
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_sreq", 32'(s_req), 32'd0);
    c = 0; done = 1'b0; data = 1'b0;
    while (!done) begin
      @(negedge clk);
      s_ack = (c == ack_dly);
      s_rxe = rd && (c == ack_dly) && (rxe_dly == 0);
      #1;
      to = (c == TO - 1) && (c != ack_dly);
      chk("a_sreq", 32'(s_req), 32'd1);
      chk("a_busy", 32'(busy), 32'd1);
      chk("a_grant", 32'(grant), 32'(w));
      chk("a_sadr", s_adr, adr[w]);
      chk("a_stxd", s_txd, txd[w]);
      chk("a_srwn", 32'(s_rwn), 32'(rwn[w]));
      chk("a_swen", 32'(s_wen), 32'(wen[w]));
      chk("a_ack", 32'(ack[w]), 32'((c == ack_dly) || to));
      chk("a_ack_other", 32'(ack[!w]), 32'd0);
      chk("a_err", 32'(err[w]), 32'(to));
      chk("a_err_other", 32'(err[!w]), 32'd0);
      chk("a_rxe", 32'(rxe[w]), 32'(rd && (s_rxe || to)));
      chk("a_rxe_other", 32'(rxe[!w]), 32'd0);
      chk("a_rxd_other", rxd[!w], 32'd0);
      if (rxe[w]) chk("a_rxd", rxd[w], to ? 32'd0 : rdat);
      data = rd && (c == ack_dly) && (rxe_dly != 0);
      done = (c == ack_dly) || to;
      c++;
    end
    c = 0;
    while (data) begin
      @(negedge clk);
      s_ack = 1'b0;
      s_rxe = (c == rxe_dly - 1);
      #1;
      to = (c == TO - 1) && !s_rxe;
      chk("d_sreq", 32'(s_req), 32'd0);
      chk("d_busy", 32'(busy), 32'd1);
      chk("d_ack", 32'(ack), 32'd0);
      chk("d_rxe", 32'(rxe[w]), 32'(s_rxe || to));
      chk("d_rxe_other", 32'(rxe[!w]), 32'd0);
      chk("d_err", 32'(err[w]), 32'(to));
      chk("d_rxd_other", rxd[!w], 32'd0);
      if (rxe[w]) chk("d_rxd", rxd[w], to ? 32'd0 : rdat);
      data = !(s_rxe || to);
      c++;
    end
    @(negedge clk);
    req = '0;
    s_ack = late; s_rxe = late;
    #1;
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_sreq", 32'(s_req), 32'd0);
    chk_quiet("end");
  endtask

  task automatic set_cmd(input int m, input logic [31:0] a, input logic [31:0] d, input logic r, input logic [1:0] e);
    adr[m] = a; txd[m] = d; rwn[m] = r; wen[m] = e;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) set_cmd(m, 32'd0, 32'd0, 1'b0, 2'b00);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sreq", 32'(s_req), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sadr", s_adr, 32'd0);
    chk("rst_stxd", s_txd, 32'd0);
    chk_quiet("rst");
    @(negedge clk);
    rst_n = 1'b1;
    last = 1'b1;
    // simultaneous writes alternate 0,1,0,1 from reset
    for (int i = 0; i < 4; i++) begin
      set_cmd(0, 32'h0000_0100 + 32'(i), 32'hA000_0000 + 32'(i), 1'b0, 2'b01);
      set_cmd(1, 32'h0000_0200 + 32'(i), 32'hB000_0000 + 32'(i), 1'b0, 2'b10);
      txn(2'b11, 0, 0, 1'b0);
    end
    set_cmd(0, 32'h0000_1004, 32'hCAFE_0001, 1'b0, 2'b11);
    txn(2'b01, 2, 0, 1'b0);
    set_cmd(1, 32'h0000_2000, 32'h0, 1'b1, 2'b00);
    rdat = 32'h1234_5678;
    txn(2'b10, 0, 3, 1'b0);
    txn(2'b10, 1, 0, 1'b0);
    set_cmd(0, 32'h0000_3000, 32'h0, 1'b1, 2'b00);
    txn(2'b01, 20, 0, 1'b1);
    txn(2'b01, 0, 20, 1'b1);
    txn(2'b01, TO - 1, 0, 1'b0);
    // reset in the data phase of an m1 read
    set_cmd(1, 32'h0000_4444, 32'h5555_0000, 1'b1, 2'b11);
    @(negedge clk);
    s_ack = 1'b0; s_rxe = 1'b0;
    req = 2'b10;
    @(negedge clk);
    s_ack = 1'b1;
    @(negedge clk);
    s_ack = 1'b0;
    #1;
    chk("mid_busy_data", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    s_rxe = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_sreq", 32'(s_req), 32'd0);
    chk("mid_grant", 32'(grant), 32'd0);
    chk("mid_sadr", s_adr, 32'd0);
    chk("mid_stxd", s_txd, 32'd0);
    chk("mid_srwn", 32'(s_rwn), 32'd0);
    chk("mid_swen", 32'(s_wen), 32'd0);
    chk_quiet("mid");
    req = '0; s_rxe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last = 1'b1;
    rwn[1] = 1'b0;
    txn(2'b10, 1, 0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      for (int m = 0; m < 2; m++)
        set_cmd(m, $urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      rdat = $urandom;
      txn(2'($urandom_range(1, 3)), $urandom_range(0, 9), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
